lfsr5_sched: RTL and testbench
==============================

# lfsr5_sched

Round-robin scheduler that shares one 5-bit LFSR pseudo-random source among up to N_REQ requesters. Each grant advances the LFSR by exactly one step and hands the new value to the granted requester, so no two requesters ever receive the same draw. The block also owns seeding of the LFSR and an optional free-running "whitening" mode while idle. It sits between the LFSR datapath and its consumers, such as test-pattern and backoff logic.

## Interface
- N_REQ, 4, number of requesters; legal range 2..8.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester request level; held until the matching gnt bit is seen.
- gnt  out  N_REQ  one-hot grant, registered; high for exactly one cycle per grant.
- rnd_valid  out  1  high in the same cycle as gnt; rnd carries the draw for that grant.
- rnd  out  5  last drawn value; holds between grants.
- run_en  in  1  when 1, the LFSR steps every cycle that the block is IDLE with no other action.
- seed_we  in  1  seed load strobe, one cycle.
- seed  in  5  seed value, sampled with seed_we.
- seed_err  out  1  one-cycle pulse: a zero seed was written and replaced with the default.

## Operation
- LFSR state is s[4:0]. One step computes next state n as follows:
  - n0 = s4
  - n1 = s0
  - n2 = s1
  - n3 = s2 ^ s4
  - n4 = s4 ^ s3
- Default and reset state is 5'b11111. The state 5'b00000 is forbidden because it locks the LFSR.
- The FSM has two states: IDLE and ISSUE.
- At an edge in IDLE, the highest-priority case below applies:
  1. seed_we=1: load the LFSR with seed. If seed==0, load 5'b11111 instead and pulse seed_err. Requests are not served at this edge; the FSM stays in IDLE.
  2. req≠0: pick the first set bit searching from ptr upward, wrapping modulo N_REQ. Then, all at the same edge:
     - step the LFSR;
     - set rnd to the new state;
     - set gnt to the one-hot pick and set rnd_valid to 1;
     - set ptr to (pick+1) mod N_REQ;
     - go to ISSUE.
  3. run_en=1: step the LFSR. rnd does not change.
  4. Otherwise hold all state.
- At an edge in ISSUE:
  - clear gnt and rnd_valid and return to IDLE;
  - apply seed_we with the same zero rule as IDLE;
  - do not step the LFSR, even if run_en=1;
  - ignore req.
- The mandatory ISSUE cycle gives a requester one cycle to drop req after seeing gnt.
- A req bit that is still high in the next IDLE cycle is treated as a new request.
- If seed_we is asserted on consecutive cycles, each write is applied and the last one wins.
- ptr advances only on a grant; seeding and free-running never move it.

## Timing
- Reset values: gnt=0, rnd_valid=0, rnd=5'b00000, seed_err=0, LFSR=5'b11111, ptr=0, FSM=IDLE.
- Asserting rst_b mid-ISSUE clears gnt and rnd_valid immediately, without waiting for a clock.
- Latency: req sampled at edge k in IDLE gives gnt and rnd_valid high during cycle k..k+1.
- Throughput: at most one grant every 2 cycles.
- seed_err is high in the cycle after the offending seed_we edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package lfsr5_pkg holds:
  - LFSR_W = 5;
  - LFSR_DEFAULT = 5'b11111;
  - FSM state typedef {IDLE, ISSUE}.
- Sub-module lfsr5_core contains the LFSR register and next-state logic, with ports clk, rst_b, step, load, load_val and q.
- lfsr5_core resets to LFSR_DEFAULT, and load takes priority over step.
- The scheduler contains the FSM, the round-robin pointer/priority search, the zero-seed check and the output registers.

## Test plan
- Single request: after reset, req=4'b0001 held → gnt=0001 and rnd_valid=1 for one cycle with rnd=5'b00111. In the next cycle gnt=0, rnd_valid=0, and rnd stays 00111.
- All requesting: req=4'b1111 held → grants on alternate cycles with no back-to-back gnt.
  - gnt sequence: 0001, 0010, 0100, 1000, 0001.
  - rnd sequence: 00111, 01110, 11100, 00001.
- Zero seed: seed_we=1 with seed=0 → seed_err pulses once and the LFSR is 11111. The next grant returns rnd=00111.
- Seed vs request: seed_we=1 with seed=01110 and req=0100 at the same IDLE edge → no grant at that edge. At the next edge gnt=0100 and rnd=11100.
- Free-running: after reset, run_en=1 for 3 idle cycles, then req=0010 → gnt=0010 with rnd=00001. Repeat with run_en held during ISSUE and confirm no extra step occurs.
- Reset mid-operation: assert rst_b low during ISSUE → gnt=0 and rnd_valid=0 without waiting for a clock edge. After release, the first grant goes to requester 0 if requesting, with rnd=00111.

Source files
------------

// File: rtl/lfsr5_pkg.sv
// Shared definitions for the 5-bit LFSR scheduler: width, default state,
// FSM encoding and the single-step next-state function.
package lfsr5_pkg;

  localparam int LFSR_W = 5;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT = 5'b11111;

  typedef enum logic {
    IDLE,
    ISSUE
  } sched_state_t;

  // One LFSR advance; the all-zero state is a lock-up point and must never be loaded.
  function automatic logic [LFSR_W-1:0] lfsr5_step(input logic [LFSR_W-1:0] s);
    return {s[4] ^ s[3], s[2] ^ s[4], s[1], s[0], s[4]};
  endfunction

endpackage

// File: rtl/lfsr5_core.sv
// 5-bit LFSR register: parallel load wins over a single step.
module lfsr5_core
  import lfsr5_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q <= LFSR_DEFAULT;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= lfsr5_step(q);
    end
  end

endmodule

// File: rtl/lfsr5_sched.sv
// Round-robin scheduler handing out one LFSR draw per grant, with seeding
// (zero seed replaced by the default) and optional idle free-running.
module lfsr5_sched
  import lfsr5_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic              rnd_valid,
  output logic [LFSR_W-1:0] rnd,
  input  logic              run_en,
  input  logic              seed_we,
  input  logic [LFSR_W-1:0] seed,
  output logic              seed_err
);

  localparam int PTR_W = $clog2(N_REQ);

  sched_state_t      state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0]  gnt_d;
  logic              vld_d;
  logic [LFSR_W-1:0] rnd_d;
  logic              err_d;

  logic              lfsr_step, lfsr_load;
  logic [LFSR_W-1:0] lfsr_load_val, lfsr_q;
  logic              seed_zero;

  logic              found;
  logic [PTR_W-1:0]  pick, cand;

  // (base + off) mod N_REQ, with off < N_REQ and base < N_REQ.
  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[PTR_W-1:0];
  endfunction

  lfsr5_core u_core (
    .clk      (clk),
    .rst_b    (rst_b),
    .step     (lfsr_step),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .q        (lfsr_q)
  );

  assign seed_zero     = (seed == '0);
  assign lfsr_load_val = seed_zero ? LFSR_DEFAULT : seed;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = rr_idx(ptr_q, i);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    vld_d     = 1'b0;
    rnd_d     = rnd;
    err_d     = 1'b0;
    lfsr_step = 1'b0;
    lfsr_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (seed_we) begin
          lfsr_load = 1'b1;
          err_d     = seed_zero;
        end else if (found) begin
          lfsr_step = 1'b1;
          rnd_d     = lfsr5_step(lfsr_q);
          gnt_d     = N_REQ'(1) << pick;
          vld_d     = 1'b1;
          ptr_d     = rr_idx(pick, 1);
          state_d   = ISSUE;
        end else if (run_en) begin
          lfsr_step = 1'b1;
        end
      end
      ISSUE: begin
        // Dead cycle lets the granted requester drop req; the LFSR holds.
        state_d = IDLE;
        if (seed_we) begin
          lfsr_load = 1'b1;
          err_d     = seed_zero;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd       <= '0;
      seed_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt       <= gnt_d;
      rnd_valid <= vld_d;
      rnd       <= rnd_d;
      seed_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_lfsr5_sched.sv
// Scoreboard bench for lfsr5_sched: stimulus queues expected grants and
// seed errors; a negedge monitor pops and compares what the DUT presents.
module tb_lfsr5_sched;

  logic       clk;
  logic       rst_b;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       rnd_valid;
  logic [4:0] rnd;
  logic       run_en;
  logic       seed_we;
  logic [4:0] seed;
  logic       seed_err;

  typedef struct packed {
    logic [3:0] g;
    logic [4:0] r;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   exp_err = 0;
  int   checks  = 0;
  int   fails   = 0;
  logic prev_vld = 1'b0;

  lfsr5_sched #(.N_REQ(4)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .req       (req),
    .gnt       (gnt),
    .rnd_valid (rnd_valid),
    .rnd       (rnd),
    .run_en    (run_en),
    .seed_we   (seed_we),
    .seed      (seed),
    .seed_err  (seed_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic do_reset();
    rst_b   = 1'b0;
    req     = '0;
    run_en  = 1'b0;
    seed_we = 1'b0;
    seed    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  task automatic wait_gnt(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (gnt != 4'b0000) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_timeout: gnt stayed 0, grant required within 20 cycles", name);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input logic [3:0] g, input logic [4:0] r);
    exp_t e;
    e.g = g;
    e.r = r;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented grant or seed error must match the next expectation.
  always @(negedge clk) begin
    if (rnd_valid || gnt != 4'b0000) begin
      check("gnt_matches_valid", 32'(gnt != 4'b0000), 32'(rnd_valid));
      check("no_back_to_back", 32'(prev_vld), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_grant: gnt=%b rnd=%b, no grant expected", gnt, rnd);
      end else begin
        mon_e = exp_q.pop_front();
        check("grant_gnt", 32'(gnt), 32'(mon_e.g));
        check("grant_rnd", 32'(rnd), 32'(mon_e.r));
      end
    end
    if (seed_err) begin
      checks++;
      if (exp_err == 0) begin
        fails++;
        $display("FAIL unexpected_seed_err: seed_err=1, expected 0");
      end else begin
        exp_err--;
      end
    end
    prev_vld = rnd_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_rnd_valid", 32'(rnd_valid), 32'd0);
    check("reset_rnd", 32'(rnd), 32'd0);
    check("reset_seed_err", 32'(seed_err), 32'd0);

    // Single request
    expect_grant(4'b0001, 5'b00111);
    req = 4'b0001;
    wait_gnt("single");
    req = '0;
    idle(1);
    check("single_gnt_clear", 32'(gnt), 32'd0);
    check("single_vld_clear", 32'(rnd_valid), 32'd0);
    check("single_rnd_hold", 32'(rnd), 32'(5'b00111));
    idle(2);

    // All requesting: grants on alternate edges, round-robin order
    do_reset();
    expect_grant(4'b0001, 5'b00111);
    expect_grant(4'b0010, 5'b01110);
    expect_grant(4'b0100, 5'b11100);
    expect_grant(4'b1000, 5'b00001);
    expect_grant(4'b0001, 5'b00010);
    req = 4'b1111;
    repeat (9) @(posedge clk);
    #1;
    req = '0;
    idle(3);

    // Zero seed restores the default state
    do_reset();
    expect_grant(4'b0001, 5'b00111);
    req = 4'b0001;
    wait_gnt("zseed_pre");
    req = '0;
    idle(1);
    seed_we = 1'b1;
    seed    = 5'b00000;
    exp_err++;
    idle(1);
    seed_we = 1'b0;
    expect_grant(4'b0001, 5'b00111);
    req = 4'b0001;
    wait_gnt("zseed_post");
    req = '0;
    idle(2);

    // Seed beats request at the same edge
    do_reset();
    seed_we = 1'b1;
    seed    = 5'b01110;
    req     = 4'b0100;
    idle(1);
    seed_we = 1'b0;
    check("seed_blocks_grant", 32'(gnt), 32'd0);
    expect_grant(4'b0100, 5'b11100);
    wait_gnt("seed_req");
    req = '0;
    idle(2);

    // Free-running for three idle cycles
    do_reset();
    run_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_en = 1'b0;
    expect_grant(4'b0010, 5'b00001);
    req = 4'b0010;
    wait_gnt("freerun");
    req = '0;
    idle(2);

    // Free-running held through ISSUE must not add a step
    do_reset();
    run_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_grant(4'b0010, 5'b00001);
    req = 4'b0010;
    wait_gnt("freerun_issue");
    req = '0;
    idle(1);
    run_en = 1'b0;
    expect_grant(4'b0001, 5'b00010);
    req = 4'b0001;
    wait_gnt("freerun_issue_next");
    req = '0;
    idle(2);

    // Asynchronous reset during ISSUE
    do_reset();
    expect_grant(4'b0001, 5'b00111);
    req = 4'b0011;
    wait_gnt("midreset_pre");
    @(negedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'd0);
    check("async_rst_vld", 32'(rnd_valid), 32'd0);
    check("async_rst_rnd", 32'(rnd), 32'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    expect_grant(4'b0001, 5'b00111);
    wait_gnt("midreset_post");
    req = '0;
    idle(3);

    check("grants_all_seen", 32'(exp_q.size()), 32'd0);
    check("seed_errs_all_seen", 32'(exp_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
